// File: rtl/background_fb_scheduler.sv
// background_fb_scheduler: shares the single-port background RAM between scanout reads (priority) and loader writes.
// Define BG_FRAME_LATCH_EN to sample scroll/layout only on frame_start; otherwise they also reload at each line start.
module background_fb_scheduler #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic [9:0]        x_position,
  input  logic [9:0]        y_position,
  input  logic [2:0]        layout,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_oob,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid
);
  localparam logic [9:0] HR = 10'(H_RES);
  localparam logic [9:0] HM1 = 10'(H_RES - 1);
  localparam logic [9:0] HH = 10'(H_RES / 2);
  localparam logic [9:0] VR = 10'(V_RES);
  localparam logic [9:0] VM1 = 10'(V_RES - 1);
  localparam logic [8:0] YM1 = 9'(V_RES - 1);
  localparam logic [8:0] VH = 9'(V_RES / 2);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_RES);
`ifdef BG_FRAME_LATCH_EN
  localparam bit LINE_LOAD = 1'b0;
`else
  localparam bit LINE_LOAD = 1'b1;
`endif
  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DONE} state_t;
  state_t state, state_n;
  logic [9:0] scan_x, x_n, x_off, y_off, xo_in, y1, yo_in, x_e, y_e, imx, imy, col, row, sy;
  logic [8:0] scan_y, y_n;
  logic [10:0] sx;
  logic [2:0] lay_q, lay_e;
  logic accept, line_load, wr_fire, oob, rd_pend;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  assign accept = pix_en && state == ACTIVE && !frame_start;
  assign wr_ready = !(pix_en && state == ACTIVE) && !reset;
  assign wr_fire = wr_valid && wr_ready;
  assign oob = wr_x >= HR || {1'b0, wr_y} >= VR;
  assign line_load = LINE_LOAD && accept && scan_x == '0;
  assign wr_addr = ADDR_W'(wr_y) * HA + ADDR_W'(wr_x);
  always_comb begin
    xo_in = x_position >= HR ? x_position - HR : x_position;
    y1 = y_position >= VR ? y_position - VR : y_position;
    yo_in = y1 >= VR ? y1 - VR : y1;
    // a line-start reload must already steer the pixel that triggers it
    x_e = line_load ? xo_in : x_off;
    y_e = line_load ? yo_in : y_off;
    lay_e = line_load ? layout : lay_q;
    sx = {1'b0, scan_x} + {1'b0, x_e};
    imx = sx >= {1'b0, HR} ? 10'(sx - {1'b0, HR}) : sx[9:0];
    sy = {1'b0, scan_y} + y_e;
    imy = sy >= VR ? sy - VR : sy;
    col = lay_e == 3'd0 ? imx : lay_e == 3'd1 ? scan_x : scan_x < HH ? imx : HM1 - imx;
    row = lay_e == 3'd0 ? {1'b0, scan_y} : lay_e == 3'd1 ? imy : scan_y < VH ? imy : VM1 - imy;
    rd_addr = ADDR_W'(row) * HA + ADDR_W'(col);
  end
  always_comb begin
    state_n = state;
    x_n = scan_x;
    y_n = scan_y;
    if (frame_start) begin
      state_n = ACTIVE;
      x_n = '0;
      y_n = '0;
    end else if (accept) begin
      x_n = scan_x == HM1 ? '0 : scan_x + 1'b1;
      y_n = scan_x != HM1 ? scan_y : scan_y == YM1 ? '0 : scan_y + 1'b1;
      state_n = scan_x == HM1 && scan_y == YM1 ? DONE : ACTIVE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_FRAME;
      scan_x <= '0;
      scan_y <= '0;
      x_off <= '0;
      y_off <= '0;
      lay_q <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      wr_oob <= 1'b0;
      rd_pend <= 1'b0;
      pix_valid <= 1'b0;
      pix_out <= '0;
    end else begin
      state <= state_n;
      scan_x <= x_n;
      scan_y <= y_n;
      if (frame_start || line_load) begin
        x_off <= xo_in;
        y_off <= yo_in;
        lay_q <= layout;
      end
      ram_en <= accept || (wr_fire && !oob);
      ram_we <= !accept && wr_fire && !oob;
      ram_addr <= accept ? rd_addr : wr_addr;
      ram_wdata <= accept ? '0 : wr_data;
      wr_oob <= wr_fire && oob;
      rd_pend <= ram_en && !ram_we;
      pix_valid <= rd_pend;
      if (rd_pend) pix_out <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_background_fb_scheduler.sv
// tb_background_fb_scheduler: directed bench; a 640x480 instance plus an 8x4 instance for whole-frame checks.
module tb_background_fb_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic frame_start = 0, pix_en = 0, wr_valid = 0;
  logic [9:0] x_position = 0, y_position = 0, wr_x = 0;
  logic [8:0] wr_y = 0;
  logic [2:0] layout = 0;
  logic [7:0] wr_data = 0, ram_rdata = 0, ram_wdata, pix_out;
  logic wr_ready, wr_oob, ram_en, ram_we, pix_valid;
  logic [18:0] ram_addr;
  logic s_frame_start = 0, s_pix_en = 0;
  logic [2:0] s_layout = 3'd2;
  logic [7:0] s_rdata = 0, s_wdata, s_pix_out;
  logic s_wr_ready, s_wr_oob, s_ram_en, s_ram_we, s_pix_valid;
  logic [18:0] s_ram_addr;
  logic [7:0] mem [0:307199];
  logic [7:0] smem [0:31];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  background_fb_scheduler dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_en(pix_en),
    .x_position(x_position), .y_position(y_position), .layout(layout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_oob(wr_oob), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pix_out(pix_out), .pix_valid(pix_valid));
  background_fb_scheduler #(.H_RES(8), .V_RES(4)) sdut (
    .clk(clk), .reset(reset), .frame_start(s_frame_start), .pix_en(s_pix_en),
    .x_position(10'd0), .y_position(10'd0), .layout(s_layout),
    .wr_valid(1'b0), .wr_ready(s_wr_ready), .wr_x(10'd0), .wr_y(9'd0), .wr_data(8'd0),
    .wr_oob(s_wr_oob), .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_addr(s_ram_addr),
    .ram_wdata(s_wdata), .ram_rdata(s_rdata), .pix_out(s_pix_out), .pix_valid(s_pix_valid));
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    else if (ram_en) ram_rdata <= mem[ram_addr];
    if (s_ram_en) s_rdata <= smem[s_ram_addr[4:0]];
  end
  function automatic logic [7:0] pat(int a);
    return 8'(a * 5 + (a >> 8));
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    reset = 1; frame_start = 0; pix_en = 0; wr_valid = 0; layout = 0; x_position = 0; y_position = 0;
    tick; tick;
    reset = 0;
  endtask
  task automatic start_frame;
    frame_start = 1; tick; frame_start = 0;
  endtask
  task automatic test_reset;
    reset = 1; pix_en = 0;
    #2;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, wr_ready, wr_oob, pix_out, pix_valid} !== '0) begin
      errors++; $display("FAIL reset_outputs got %0h exp 0", {ram_en, ram_we, ram_addr, ram_wdata, wr_ready, wr_oob, pix_out, pix_valid});
    end
    tick; reset = 0; #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    pix_en = 1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      checks++;
      if (ram_en !== 1'b0 || wr_ready !== 1'b1) begin
        errors++; $display("FAIL wait_frame_ignore c=%0d ram_en %b wr_ready %b exp 0/1", c, ram_en, wr_ready);
      end
    end
    pix_en = 0;
  endtask
  task automatic test_latency;
    apply_reset; start_frame; pix_en = 1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      checks++;
      if (ram_en !== (c <= 6) || (c <= 6 && (ram_we !== 1'b0 || ram_addr !== 19'(c - 1)))) begin
        errors++; $display("FAIL lat_ram c=%0d en %b we %b addr %0d exp en %b addr %0d", c, ram_en, ram_we, ram_addr, c <= 6, c - 1);
      end
      checks++;
      if (pix_valid !== (c >= 3 && c <= 8)) begin
        errors++; $display("FAIL lat_valid c=%0d got %b exp %b", c, pix_valid, c >= 3 && c <= 8);
      end
      if (c >= 3) begin
        checks++;
        if (pix_out !== pat(c >= 9 ? 5 : c - 3)) begin
          errors++; $display("FAIL lat_pix c=%0d got %0h exp %0h", c, pix_out, pat(c >= 9 ? 5 : c - 3));
        end
      end
      if (c == 6) pix_en = 0;
    end
  endtask
  task automatic test_scroll;
    apply_reset; x_position = 700; start_frame; pix_en = 1;
    for (int c = 1; c <= 641; c++) begin
      tick;
      if (c == 591 || c == 640 || c == 641) begin
        checks++;
        if (ram_addr !== (c == 591 ? 19'd10 : c == 640 ? 19'd59 : 19'd700)) begin
          errors++; $display("FAIL hscroll c=%0d got %0d exp %0d", c, ram_addr, c == 591 ? 10 : c == 640 ? 59 : 700);
        end
      end
    end
    pix_en = 0;
  endtask
  task automatic test_vscroll;
`ifdef BG_FRAME_LATCH_EN
    int e641 = 40960, e646 = 40965;
`else
    int e641 = 640, e646 = 645;
`endif
    apply_reset; layout = 1; y_position = 1023; start_frame; pix_en = 1;
    for (int c = 1; c <= 646; c++) begin
      tick;
      if (c == 1 || c == 6 || c == 641 || c == 646) begin
        checks++;
        if (ram_addr !== 19'(c == 1 ? 40320 : c == 6 ? 40325 : c == 641 ? e641 : e646)) begin
          errors++; $display("FAIL vscroll c=%0d got %0d exp %0d", c, ram_addr, c == 1 ? 40320 : c == 6 ? 40325 : c == 641 ? e641 : e646);
        end
      end
      if (c == 10) y_position = 0;
    end
    pix_en = 0;
  endtask
  task automatic test_arbitration;
    logic pe;
    apply_reset; start_frame; wr_valid = 1; wr_y = 200;
    for (int c = 0; c < 8; c++) begin
      pe = (c % 2 == 0); pix_en = pe; wr_x = 10'(c); wr_data = 8'(c + 50);
      #1;
      checks++;
      if (wr_ready !== !pe) begin errors++; $display("FAIL arb_ready c=%0d got %b exp %b", c, wr_ready, !pe); end
      tick;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== !pe || ram_addr !== (pe ? 19'(c / 2) : 19'(200 * 640 + c))
          || (!pe && ram_wdata !== 8'(c + 50))) begin
        errors++; $display("FAIL arb_port c=%0d en %b we %b addr %0d data %0d exp we %b addr %0d", c, ram_en, ram_we, ram_addr, ram_wdata, !pe, pe ? c / 2 : 200 * 640 + c);
      end
    end
    pix_en = 0; wr_x = 640; wr_y = 0;
    tick;
    checks++;
    if (wr_oob !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL oob_x oob %b en %b exp 1/0", wr_oob, ram_en); end
    wr_x = 5; wr_y = 480;
    tick;
    checks++;
    if (wr_oob !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL oob_y oob %b en %b exp 1/0", wr_oob, ram_en); end
    wr_valid = 0;
    tick;
    checks++;
    if (wr_oob !== 1'b0) begin errors++; $display("FAIL oob_pulse got %b exp 0", wr_oob); end
  endtask
  task automatic test_back_to_back;
    apply_reset; start_frame; pix_en = 1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c <= 5 || c >= 7) begin
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 19'(c <= 5 ? c - 1 : c - 7)) begin
          errors++; $display("FAIL b2b_addr c=%0d en %b addr %0d exp %0d", c, ram_en, ram_addr, c <= 5 ? c - 1 : c - 7);
        end
      end else begin
        checks++;
        if (ram_en !== 1'b0) begin errors++; $display("FAIL restart_ignore got %b exp 0", ram_en); end
      end
      if (c >= 7) begin
        checks++;
        if (pix_valid !== (c != 8)) begin errors++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, pix_valid, c != 8); end
      end
      frame_start = (c == 5);
    end
    pix_en = 0;
  endtask
  task automatic test_reset_mid;
    apply_reset; start_frame; pix_en = 1;
    tick; tick; tick;
    #1 reset = 1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL mid_reset valid %b en %b exp 0/0", pix_valid, ram_en); end
    tick; tick; reset = 0;
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++;
      if (pix_valid !== 1'b0 || ram_en !== 1'b0) begin
        errors++; $display("FAIL post_reset c=%0d valid %b en %b exp 0/0", c, pix_valid, ram_en);
      end
    end
    start_frame;
    tick;
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 19'd0) begin errors++; $display("FAIL reset_restart en %b addr %0d exp 1/0", ram_en, ram_addr); end
    pix_en = 0;
  endtask
  task automatic test_quadrant_done;
    int qi[7] = '{4, 7, 11, 13, 18, 24, 31};
    int qa[7] = '{3, 0, 11, 10, 10, 0, 0};
    int cnt = 0;
    s_frame_start = 1; tick; s_frame_start = 0; s_pix_en = 1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (s_pix_valid) cnt++;
      for (int k = 0; k < 7; k++) if (c == qi[k] + 1) begin
        checks++;
        if (s_ram_en !== 1'b1 || s_ram_addr !== 19'(qa[k])) begin
          errors++; $display("FAIL quad idx=%0d en %b addr %0d exp %0d", qi[k], s_ram_en, s_ram_addr, qa[k]);
        end
      end
      if (c >= 33) begin
        checks++;
        if (s_ram_en !== 1'b0 || s_wr_ready !== 1'b1) begin
          errors++; $display("FAIL done_ignore c=%0d en %b ready %b exp 0/1", c, s_ram_en, s_wr_ready);
        end
      end
    end
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL frame_valid_count got %0d exp 32", cnt); end
    s_frame_start = 1; tick; s_frame_start = 0; tick;
    checks++;
    if (s_ram_en !== 1'b1 || s_ram_addr !== 19'd0) begin errors++; $display("FAIL done_restart en %b addr %0d exp 1/0", s_ram_en, s_ram_addr); end
    s_pix_en = 0;
  endtask
  initial begin
    for (int i = 0; i < 307200; i++) mem[i] = pat(i);
    for (int i = 0; i < 32; i++) smem[i] = 8'(i + 100);
    tick;
    test_reset;
    test_latency;
    test_scroll;
    test_vscroll;
    test_arbitration;
    test_back_to_back;
    test_reset_mid;
    apply_reset;
    test_quadrant_done;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
